// File: rtl/cpu_run_controller.sv
// Run controller for the single-clock MIPS core: stretched core reset, run/retire
// counters and end-of-program detection (branch-to-self halt or cycle timeout).
module cpu_run_controller #(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 4,
  parameter int STALL_LIMIT = 16,
  parameter int TIMEOUT     = 100000,
  parameter int AUTO_START  = 1
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             pc_valid_i,
  input  logic             retire_i,
  output logic             core_reset_o,
  output logic             running_o,
  output logic             done_o,
  output logic [1:0]       status_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_e;

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int SC_W = $clog2(STALL_LIMIT);

  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [SC_W-1:0]  SC_HALT = SC_W'(STALL_LIMIT - 2);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_HALT    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  state_e           state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [1:0]       status_q, status_d;
  logic [SC_W-1:0]  stall_q, stall_d;
  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic             last_pc_vld_q, last_pc_vld_d;

  logic pc_match, halt, timeout, enter_reset;

  // NOTE: every variable gets its hold value first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_cnt_d   = cycle_cnt_q;
    instr_cnt_d   = instr_cnt_q;
    status_d      = status_q;
    stall_d       = stall_q;
    last_pc_d     = last_pc_q;
    last_pc_vld_d = last_pc_vld_q;
    enter_reset   = 1'b0;

    pc_match = last_pc_vld_q && (pc_i == last_pc_q);
    halt     = pc_valid_i && pc_match && (stall_q == SC_HALT);
    timeout  = (cycle_cnt_q == TO_LAST);

    case (state_q)
      S_IDLE: begin
        if ((AUTO_START != 0) || start_i) enter_reset = 1'b1;
      end
      S_RESET: begin
        if (rst_cnt_q == RC_LAST) state_d = S_RUN;
        else                      rst_cnt_d = rst_cnt_q + 1'b1;
      end
      S_RUN: begin
        if (cycle_cnt_q != CNT_MAX)             cycle_cnt_d = cycle_cnt_q + 1'b1;
        if (retire_i && instr_cnt_q != CNT_MAX) instr_cnt_d = instr_cnt_q + 1'b1;
        if (pc_valid_i) begin
          stall_d       = pc_match ? stall_q + 1'b1 : '0;
          last_pc_d     = pc_i;
          last_pc_vld_d = 1'b1;
        end
        // Halt wins when both end conditions land on the same cycle.
        if (halt || timeout) begin
          state_d  = S_DONE;
          status_d = halt ? ST_HALT : ST_TIMEOUT;
        end
      end
      S_DONE: begin
        if (start_i) enter_reset = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_reset) begin
      state_d       = S_RESET;
      rst_cnt_d     = '0;
      cycle_cnt_d   = '0;
      instr_cnt_d   = '0;
      status_d      = ST_NONE;
      stall_d       = '0;
      last_pc_vld_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset_i) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      cycle_cnt_q   <= '0;
      instr_cnt_q   <= '0;
      status_q      <= ST_NONE;
      stall_q       <= '0;
      last_pc_q     <= '0;
      last_pc_vld_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instr_cnt_q   <= instr_cnt_d;
      status_q      <= status_d;
      stall_q       <= stall_d;
      last_pc_q     <= last_pc_d;
      last_pc_vld_q <= last_pc_vld_d;
    end
  end

  assign core_reset_o = (state_q != S_RUN);
  assign running_o    = (state_q == S_RUN);
  assign done_o       = (state_q == S_DONE);
  assign status_o     = status_q;
  assign cycle_cnt_o  = cycle_cnt_q;
  assign instr_cnt_o  = instr_cnt_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: auto-start instance (TIMEOUT=50) and a
// manual-start instance, checked with immediate assertions after each edge.
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        rst_a, start_a, rst_b, start_b;
  logic [31:0] pc;
  logic        pc_valid, retire;

  logic        core_reset_a, running_a, done_a;
  logic [1:0]  status_a;
  logic [31:0] cycle_a, instr_a;
  logic        core_reset_b, running_b, done_b;
  logic [1:0]  status_b;
  logic [31:0] cycle_b, instr_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_run_controller #(
    .PC_W(32), .CNT_W(32), .RST_CYCLES(4), .STALL_LIMIT(16), .TIMEOUT(50), .AUTO_START(1)
  ) dut_a (
    .clk(clk), .reset_i(rst_a), .start_i(start_a), .pc_i(pc), .pc_valid_i(pc_valid),
    .retire_i(retire), .core_reset_o(core_reset_a), .running_o(running_a), .done_o(done_a),
    .status_o(status_a), .cycle_cnt_o(cycle_a), .instr_cnt_o(instr_a)
  );

  cpu_run_controller #(
    .PC_W(32), .CNT_W(32), .RST_CYCLES(4), .STALL_LIMIT(16), .TIMEOUT(50), .AUTO_START(0)
  ) dut_b (
    .clk(clk), .reset_i(rst_b), .start_i(start_b), .pc_i(pc), .pc_valid_i(pc_valid),
    .retire_i(retire), .core_reset_o(core_reset_b), .running_o(running_b), .done_o(done_b),
    .status_o(status_b), .cycle_cnt_o(cycle_b), .instr_cnt_o(instr_b)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic cr, input logic run, input logic dn,
                         input logic [1:0] st, input logic [31:0] cc, input logic [31:0] ic);
    check({tag, "_core_reset"}, {31'd0, core_reset_a}, {31'd0, cr});
    check({tag, "_running"},    {31'd0, running_a},    {31'd0, run});
    check({tag, "_done"},       {31'd0, done_a},       {31'd0, dn});
    check({tag, "_status"},     {30'd0, status_a},     {30'd0, st});
    check({tag, "_cycle_cnt"},  cycle_a,               cc);
    check({tag, "_instr_cnt"},  instr_a,               ic);
  endtask

  task automatic restart_a(input string tag);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check_a({tag, "_reset_entry"}, 1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    repeat (3) tick();
    check({tag, "_still_reset"}, {31'd0, core_reset_a}, 32'd1);
    tick();
    check_a({tag, "_run_entry"}, 1'b0, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  initial begin
    rst_a = 1'b0; start_a = 1'b0; rst_b = 1'b0; start_b = 1'b0;
    pc = 32'h0; pc_valid = 1'b0; retire = 1'b0;

    // 1: reset, then IDLE + 4 RESET cycles before RUN
    repeat (3) tick();
    check_a("reset", 1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    rst_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("rst_stretch%0d", i), {31'd0, core_reset_a}, 32'd1);
    end
    tick();
    check_a("run_entry", 1'b0, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);

    // 2: stepping pc then 16 samples of 0x300C -> halt
    pc_valid = 1'b1;
    retire   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 32'h3000 + 32'(4 * i);
      tick();
      check($sformatf("step_cycle%0d", i), cycle_a, 32'(i + 1));
    end
    for (int i = 0; i < 16; i++) begin
      pc     = 32'h300C;
      retire = (i % 2 == 0);
      tick();
      if (i == 14) begin
        check("halt_not_yet_running", {31'd0, running_a}, 32'd1);
        check("halt_not_yet_done", {31'd0, done_a}, 32'd0);
      end
    end
    check_a("halt", 1'b1, 1'b0, 1'b1, 2'b01, 32'd19, 32'd11);
    retire = 1'b1;
    repeat (3) tick();
    check_a("halt_frozen", 1'b1, 1'b0, 1'b1, 2'b01, 32'd19, 32'd11);
    retire = 1'b0;

    // 5 + 3: restart from DONE, then timeout at 50 with start ignored in RUN
    restart_a("restart1");
    for (int i = 1; i <= 49; i++) begin
      pc      = 32'h8000 + 32'(4 * i);
      start_a = (i == 10);
      tick();
      if (i == 10) check("start_ignored_in_run", {31'd0, running_a}, 32'd1);
    end
    start_a = 1'b0;
    check("timeout_cycle49_running", {31'd0, running_a}, 32'd1);
    check("timeout_cycle49_cnt", cycle_a, 32'd49);
    pc = 32'h9000;
    tick();
    check_a("timeout", 1'b1, 1'b0, 1'b1, 2'b10, 32'd50, 32'd0);

    // 4: halt and timeout coincide on RUN cycle 50
    restart_a("restart2");
    for (int i = 1; i <= 50; i++) begin
      pc = (i <= 34) ? 32'h4000 + 32'(4 * i) : 32'h5000;
      tick();
      if (i == 49) check("coincide_cycle49_done", {31'd0, done_a}, 32'd0);
    end
    check_a("coincide", 1'b1, 1'b0, 1'b1, 2'b01, 32'd50, 32'd0);

    // 6: reset mid-RUN with cycle_cnt=20, then auto restart
    restart_a("restart3");
    retire = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      pc = 32'hA000 + 32'(4 * i);
      tick();
    end
    check("midrun_cycle", cycle_a, 32'd20);
    check("midrun_instr", instr_a, 32'd20);
    rst_a = 1'b0;
    tick();
    check_a("midrun_reset", 1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    rst_a  = 1'b1;
    retire = 1'b0;
    repeat (4) tick();
    check("auto_restart_in_reset", {31'd0, running_a}, 32'd0);
    tick();
    check("auto_restart_running", {31'd0, running_a}, 32'd1);

    // 6b: AUTO_START=0 waits in IDLE for start
    rst_b = 1'b1;
    repeat (10) tick();
    check("manual_idle_running", {31'd0, running_b}, 32'd0);
    check("manual_idle_core_reset", {31'd0, core_reset_b}, 32'd1);
    check("manual_idle_done", {31'd0, done_b}, 32'd0);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (3) tick();
    check("manual_in_reset", {31'd0, running_b}, 32'd0);
    tick();
    check("manual_running", {31'd0, running_b}, 32'd1);
    check("manual_cycle0", cycle_b, 32'd0);
    check("manual_status0", {30'd0, status_b}, 32'd0);
    check("manual_instr0", instr_b, 32'd0);
    tick();
    check("manual_cycle1", cycle_b, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Parametrised run controller for the single-clock MIPS core. It generates a stretched core reset, counts run cycles and retired instructions, and detects end-of-program. The end of a program is either a branch-to-self halt loop (PC stable) or a cycle timeout. It sits between the top-level clock/reset and the `mips` core, and it is the synthesizable successor to the bench-only clock/reset drive.

Parameters:
PC_W, 32, width of the observed program counter
CNT_W, 32, width of the cycle and instruction counters
RST_CYCLES, 4, number of cycles core_reset is held in the RESET state (≥1)
STALL_LIMIT, 16, consecutive repeated-PC samples that declare halt (≥2)
TIMEOUT, 100000, number of RUN cycles before timeout (≥1, < 2^CNT_W)
AUTO_START, 1, 1: start a run automatically after reset release; 0: wait for start

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset of this block
start  in  1  single-cycle request to (re)start a run
pc  in  PC_W  core program counter
pc_valid  in  1  pc is meaningful this cycle
retire  in  1  one instruction retired this cycle
core_reset  out  1  active-high synchronous reset to the core
running  out  1  high in the RUN state
done  out  1  high in the DONE state
status  out  2  00 none, 01 halt, 10 timeout
cycle_cnt  out  CNT_W  RUN cycles elapsed in the current/last run
instr_cnt  out  CNT_W  instructions retired in the current/last run

Behaviour:
- All state is registered on the rising edge of clk. reset=0 is sampled synchronously and overrides everything.
- Values while reset=0: state=IDLE, core_reset=1, running=0, done=0, status=00, cycle_cnt=0, instr_cnt=0, stall count 0, last-PC-valid flag 0.
- States: IDLE, RESET, RUN, DONE.
- IDLE: core_reset=1.
  - Goes to RESET on the first cycle after reset release if AUTO_START=1.
  - Otherwise goes to RESET on start=1.
- RESET: core_reset=1.
  - An internal counter runs 0..RST_CYCLES-1, so the block spends exactly RST_CYCLES cycles here, then goes to RUN.
  - On entry, cycle_cnt, instr_cnt, status, stall count and last-PC-valid are cleared.
- RUN: core_reset=0, running=1.
  - cycle_cnt increments every RUN cycle.
  - instr_cnt increments when retire=1.
  - Both counters saturate at all-ones.
  - start is ignored in RUN.
- Halt detection (RUN only):
  - When pc_valid=1 and the last-PC-valid flag is set and pc == last_pc, the stall count increments. Any other pc_valid=1 cycle clears the stall count.
  - When pc_valid=1, last_pc<=pc and the last-PC-valid flag is set.
  - pc_valid=0 leaves last_pc, the flag and the stall count unchanged.
  - Halt fires in the cycle the stall count would reach STALL_LIMIT-1. This means STALL_LIMIT consecutive valid samples of the same PC.
- Timeout: fires in the RUN cycle where cycle_cnt == TIMEOUT-1, i.e. the TIMEOUT-th RUN cycle.
- On either event, the next state is DONE and status is registered in the same edge: 01 for halt, 10 for timeout. Halt and timeout in the same cycle gives status=01.
- done/running change on the edge after the detecting cycle (1-cycle latency).
- DONE: done=1, core_reset=1 (core frozen). Counters and status hold.
  - start=1 goes to RESET (new run); it does not clear anything earlier than RESET entry.
- start in IDLE with AUTO_START=1 before the auto transition is redundant, and behaviour is identical.
- reset=0 in any state, including mid-RESET or mid-RUN, returns to IDLE with the reset values above on the next edge.
- Outputs are pure functions of registered state; there are no combinational paths from inputs to outputs.

Test Plan:
1. AUTO_START=1, RST_CYCLES=4, reset low 3 cycles then high.
   - core_reset stays 1 for the IDLE cycle plus 4 RESET cycles, then 0.
   - running=1 from the next cycle; cycle_cnt counts 1,2,3…
2. RUN, pc_valid=1, pc stepping 0x3000,0x3004,0x3008, then fixed at 0x300C with STALL_LIMIT=16.
   - done=1 and status=01 one cycle after the 16th consecutive 0x300C sample.
   - running=0, core_reset=1; counters frozen.
3. TIMEOUT=50 with an always-incrementing pc.
   - After exactly 50 RUN cycles: done=1, status=10, cycle_cnt=50.
4. Configure so that halt and timeout coincide on the same cycle.
   - status=01.
5. In DONE, pulse start.
   - RESET for RST_CYCLES cycles, counters/status cleared to 0, then RUN again.
   - A start pulse issued during RUN has no effect.
6. reset=0 asserted mid-RUN with cycle_cnt=20.
   - Next edge: IDLE, all outputs at reset values.
   - With AUTO_START=0: stays IDLE until start=1.
